// File: rtl/t_pulse_gen.sv
// t_pulse_gen: push-button toggle-request generator.
// Synchronizes and debounces a raw button, then issues single-cycle `t`
// pulses (one per press, plus optional auto-repeat while held) for the
// negative-edge T flip-flop stage downstream. All state is updated on the
// rising clock edge, so `t` is stable across the following falling edge.
module t_pulse_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned REPEAT_DELAY    = 16,
   parameter int unsigned REPEAT_PERIOD   = 8,
   parameter int unsigned CNT_W           = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn,
   input  logic             repeat_en,
   output logic             t,
   output logic             btn_state,
   output logic [CNT_W-1:0] toggle_count
);

   localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX);

   localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] DELAY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
   localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_REPEAT
   } state_e;

   logic             s1_d, s1_q;
   logic             s2_d, s2_q;
   logic [DEB_W-1:0] deb_cnt_d, deb_cnt_q;
   logic             btn_state_d, btn_state_q;
   logic             rise, fall;

   state_e           state_d, state_q;
   logic [TMR_W-1:0] timer_d, timer_q;
   logic             t_d, t_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   // Synchronizer and debounce: accept s2 once it has differed from the
   // debounced level for DEBOUNCE_CYCLES consecutive edges.
   always_comb begin
      s1_d        = btn;
      s2_d        = s1_q;
      deb_cnt_d   = '0;
      btn_state_d = btn_state_q;
      rise        = 1'b0;
      fall        = 1'b0;
      if (s2_q != btn_state_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            btn_state_d = s2_q;
            rise        = s2_q;
            fall        = ~s2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   // Synchronizer and debounce registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         deb_cnt_q   <= '0;
         btn_state_q <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         deb_cnt_q   <= deb_cnt_d;
         btn_state_q <= btn_state_d;
      end
   end

   // Press/repeat FSM: the debounced edges are decoded combinationally so
   // the press pulse lands on the same edge btn_state rises. Release is
   // checked before timer expiry so it wins when both coincide.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      t_d     = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               t_d     = 1'b1;
               timer_d = DELAY_LOAD;
               state_d = ST_ARMED;
            end
         end
         ST_ARMED, ST_REPEAT: begin
            if (fall) begin
               state_d = ST_IDLE;
            end else if (!repeat_en) begin
               timer_d = DELAY_LOAD;
               state_d = ST_ARMED;
            end else if (timer_q == '0) begin
               t_d     = 1'b1;
               timer_d = PERIOD_LOAD;
               state_d = ST_REPEAT;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (t_d) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // FSM, repeat timer, pulse and pulse-count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         t_q     <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         t_q     <= t_d;
         cnt_q   <= cnt_d;
      end
   end

   assign t            = t_q;
   assign btn_state    = btn_state_q;
   assign toggle_count = cnt_q;

endmodule

// File: tb/tb_t_pulse_gen.sv
// Directed bench for t_pulse_gen. Two instances share all inputs: one with
// default parameters and one with a 2-bit toggle_count to exercise wrap.
// Outputs are sampled 1 time unit after each rising edge; edge numbers in
// the loops count from the first edge that samples the new btn level.
module tb_t_pulse_gen;

   logic       clk;
   logic       rst_n;
   logic       btn;
   logic       repeat_en;
   logic       t;
   logic       btn_state;
   logic [7:0] toggle_count;
   logic       t2;
   logic       btn_state2;
   logic [1:0] toggle_count2;

   int n_checks;
   int n_pass;
   int exp_cnt;

   t_pulse_gen dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn          (btn),
      .repeat_en    (repeat_en),
      .t            (t),
      .btn_state    (btn_state),
      .toggle_count (toggle_count)
   );

   t_pulse_gen #(.CNT_W(2)) dut2 (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn          (btn),
      .repeat_en    (repeat_en),
      .t            (t2),
      .btn_state    (btn_state2),
      .toggle_count (toggle_count2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (time %0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      exp_cnt   = 0;
      rst_n     = 1'b0;
      btn       = 1'b0;
      repeat_en = 1'b0;

      // Reset state, then release with btn low: outputs stay 0.
      repeat (3) tick();
      check("rst_t", 32'(t), 32'd0);
      check("rst_state", 32'(btn_state), 32'd0);
      check("rst_cnt", 32'(toggle_count), 32'd0);
      rst_n = 1'b1;
      repeat (10) tick();
      check("idle_t", 32'(t), 32'd0);
      check("idle_state", 32'(btn_state), 32'd0);
      check("idle_cnt", 32'(toggle_count), 32'd0);

      // Clean press, no repeat: single pulse at edge 6.
      btn = 1'b1;
      for (int e = 1; e <= 40; e++) begin
         tick();
         check($sformatf("press_t_e%0d", e), 32'(t), 32'(e == 6));
         check($sformatf("press_bs_e%0d", e), 32'(btn_state), 32'(e >= 6));
      end
      exp_cnt++;
      check("press_cnt", 32'(toggle_count), 32'(exp_cnt));
      btn = 1'b0;
      for (int e = 1; e <= 8; e++) begin
         tick();
         check($sformatf("rel_bs_e%0d", e), 32'(btn_state), 32'(e < 6));
         check($sformatf("rel_t_e%0d", e), 32'(t), 32'd0);
      end

      // Bounce 1,0,1,0 then hold: pulse 6 edges after the stable rise.
      for (int b = 0; b < 4; b++) begin
         btn = (b % 2 == 0);
         tick();
         check($sformatf("bounce_t_b%0d", b), 32'(t), 32'd0);
      end
      btn = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick();
         check($sformatf("bounce_hold_t_e%0d", e), 32'(t), 32'(e == 6));
      end
      exp_cnt++;
      check("bounce_cnt", 32'(toggle_count), 32'(exp_cnt));
      btn = 1'b0;
      repeat (10) tick();
      check("bounce_rel_bs", 32'(btn_state), 32'd0);

      // Auto-repeat: pulses at 6, 22, 30, ..., 62; release before 70.
      repeat_en = 1'b1;
      btn       = 1'b1;
      for (int e = 1; e <= 72; e++) begin
         tick();
         check($sformatf("rep_t_e%0d", e), 32'(t),
               32'(e == 6 || (e >= 22 && e <= 62 && (e - 22) % 8 == 0)));
         if (e == 62) btn = 1'b0;
      end
      check("rep_bs_after", 32'(btn_state), 32'd0);
      exp_cnt += 7;
      check("rep_cnt", 32'(toggle_count), 32'(exp_cnt));

      // Release coincides with timer expiry at edge 22: no pulse.
      btn = 1'b1;
      for (int e = 1; e <= 32; e++) begin
         tick();
         check($sformatf("race_t_e%0d", e), 32'(t), 32'(e == 6));
         if (e >= 17) check($sformatf("race_bs_e%0d", e), 32'(btn_state), 32'(e < 22));
         if (e == 16) btn = 1'b0;
      end
      exp_cnt++;
      check("race_cnt", 32'(toggle_count), 32'(exp_cnt));
      check("race_cnt2", 32'(toggle_count2), 32'(exp_cnt % 4));

      // Reset mid-hold while t is high: immediate clear, then fresh press.
      repeat_en = 1'b0;
      btn       = 1'b1;
      for (int e = 1; e <= 6; e++) tick();
      check("mid_t_high", 32'(t), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_t", 32'(t), 32'd0);
      check("async_bs", 32'(btn_state), 32'd0);
      check("async_cnt", 32'(toggle_count), 32'd0);
      check("async_cnt2", 32'(toggle_count2), 32'd0);
      repeat (2) tick();
      rst_n   = 1'b1;
      exp_cnt = 0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         check($sformatf("rstrel_t_e%0d", e), 32'(t), 32'(e == 6));
      end
      exp_cnt++;
      check("rstrel_cnt", 32'(toggle_count), 32'(exp_cnt));
      btn = 1'b0;
      repeat (8) tick();

      // Four more presses: five since reset, 2-bit count wraps to 1.
      for (int p = 0; p < 4; p++) begin
         btn = 1'b1;
         for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("wrap_t_p%0d_e%0d", p, e), 32'(t2), 32'(e == 6));
         end
         btn = 1'b0;
         repeat (8) tick();
         exp_cnt++;
      end
      check("wrap_cnt8", 32'(toggle_count), 32'd5);
      check("wrap_cnt2", 32'(toggle_count2), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
